// File: rtl/res_bcd_display_pkg.sv
// Shared constants for the result-to-BCD display stage: FSM encoding,
// double-dabble iteration count and active-high {g..a} segment patterns.
package res_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] N_SHIFTS = 4'd8;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/res_bcd_display_seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment pattern; polarity is
// applied by the caller.
module seg7_decode
    import res_bcd_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/res_bcd_display.sv
// Sequential double-dabble converter for the 8-bit datapath result feeding a
// 3-digit multiplexed 7-segment display with leading-zero blanking.
module res_bcd_display
    import res_bcd_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  res,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_POL  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]      AN_POL   = SEG_ACTIVE_LOW ? 3'h7 : 3'h0;

    state_e      state_q;
    logic [7:0]  shreg_q;
    logic [11:0] scratch_q;
    logic [3:0]  iter_q;
    logic [11:0] bcd_q;
    logic        busy_q;
    logic        done_q;

    logic [11:0] adj_d;
    logic [19:0] shifted_d;

    always_comb begin
        adj_d     = {dd_adjust(scratch_q[11:8]), dd_adjust(scratch_q[7:4]),
                     dd_adjust(scratch_q[3:0])};
        shifted_d = {adj_d, shreg_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        shreg_q   <= res;
                        scratch_q <= '0;
                        iter_q    <= '0;
                        state_q   <= ST_SHIFT;
                        busy_q    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    {scratch_q, shreg_q} <= shifted_d;
                    iter_q               <= iter_q + 4'd1;
                    // The eighth shift lands the final digits; commit them now.
                    if (iter_q == N_SHIFTS - 4'd1) begin
                        bcd_q   <= shifted_d[19:8];
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [DIV_W-1:0] div_q;
    logic [1:0]       digit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            digit_q <= 2'd0;
        end else if (div_q == DIV_LAST) begin
            div_q   <= '0;
            digit_q <= (digit_q == 2'd2) ? 2'd0 : (digit_q + 2'd1);
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    logic [3:0] cur_nib;
    logic       cur_blank;
    logic [2:0] cur_an;
    logic [6:0] cur_seg;

    always_comb begin
        cur_nib   = bcd_q[3:0];
        cur_blank = 1'b0;
        cur_an    = 3'b001;
        case (digit_q)
            2'd1: begin
                cur_nib   = bcd_q[7:4];
                cur_blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                cur_an    = 3'b010;
            end
            2'd2: begin
                cur_nib   = bcd_q[11:8];
                cur_blank = (bcd_q[11:8] == 4'd0);
                cur_an    = 3'b100;
            end
            default: ;
        endcase
    end

    seg7_decode u_seg7_decode (
        .nibble_i (cur_nib),
        .blank_i  (cur_blank),
        .seg_o    (cur_seg)
    );

    logic [2:0] an_q;
    logic [6:0] seg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 3'b001 ^ AN_POL;
            seg_q <= SEG_0 ^ SEG_POL;
        end else begin
            an_q  <= cur_an ^ AN_POL;
            seg_q <= cur_seg ^ SEG_POL;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_res_bcd_display.sv
// Bench for res_bcd_display: a cycle-level reference built from decimal
// arithmetic and the display rules drives every expected value.
module tb_res_bcd_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  res = 8'd0;
    logic        load = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    res_bcd_display #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .res  (res),
        .load (load),
        .busy (busy),
        .done (done),
        .bcd  (bcd),
        .an   (an),
        .seg  (seg)
    );

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int d);
        int h, t, n;
        logic [6:0] p;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        n = (d == 0) ? int'(b[3:0]) : (d == 1) ? t : h;
        case (n)
            0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
            4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
            8: p = 7'h7F;  9: p = 7'h6F;  default: p = 7'h00;
        endcase
        if (d == 2 && h == 0) p = 7'h00;
        if (d == 1 && h == 0 && t == 0) p = 7'h00;
        return ~p;
    endfunction

    function automatic logic [2:0] exp_an(input int d);
        logic [2:0] a;
        a = 3'b001 << d;
        return ~a;
    endfunction

    // Reference: m_cnt counts down the 10-cycle load-to-idle window
    // (9 = just loaded, 1 = done cycle, 0 = idle).
    int          m_cnt = 0;
    logic [11:0] m_pend = '0;
    logic [11:0] m_bcd = '0;
    int          m_t = 0;
    int          m_shown_digit = 0;
    logic [11:0] m_shown_bcd = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt         <= 0;
            m_bcd         <= '0;
            m_t           <= 0;
            m_shown_digit <= 0;
            m_shown_bcd   <= '0;
        end else begin
            m_t           <= m_t + 1;
            m_shown_digit <= (m_t / SCAN_DIV) % 3;
            m_shown_bcd   <= m_bcd;
            if (m_cnt == 0) begin
                if (load) begin
                    m_cnt  <= 9;
                    m_pend <= to_bcd(int'(res));
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 2) m_bcd <= m_pend;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; res = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if (bcd !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: bcd=%h busy=%b done=%b required bcd=000 busy=0 done=0", bcd, busy, done);
        end
        total++;
        if (an !== 3'b110 || seg !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_display: an=%b seg=%b required an=110 seg=1000000", an, seg);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (an !== exp_an(m_shown_digit) || seg !== exp_seg(m_shown_bcd, m_shown_digit)) begin
                bad++;
                $display("FAIL reset_scan cyc=%0d: an=%b seg=%b required an=%b seg=%b", i, an, seg,
                         exp_an(m_shown_digit), exp_seg(m_shown_bcd, m_shown_digit));
            end
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d: busy=%b done=%b bcd=%h required 0 0 000", i, busy, done, bcd);
            end
        end
    endtask

    task automatic test_small();
        int dones, busies;
        dones = 0; busies = 0;
        res = 8'd2; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (busy !== (m_cnt >= 2) || done !== (m_cnt == 1) || bcd !== m_bcd) begin
                bad++;
                $display("FAIL small_ctrl cyc=%0d: busy=%b done=%b bcd=%h required busy=%b done=%b bcd=%h",
                         i, busy, done, bcd, m_cnt >= 2, m_cnt == 1, m_bcd);
            end
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busies++;
            @(negedge clk);
        end
        total++;
        if (dones != 1 || busies != 8) begin
            bad++;
            $display("FAIL small_pulses: done_cycles=%0d busy_cycles=%0d required 1 and 8", dones, busies);
        end
        total++;
        if (bcd !== 12'h002) begin
            bad++;
            $display("FAIL small_value: bcd=%h required 002", bcd);
        end
    endtask

    task automatic test_max();
        res = 8'd255; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        total++;
        if (bcd !== 12'h255) begin
            bad++;
            $display("FAIL max_value: bcd=%h required 255", bcd);
        end
        for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
            total++;
            if (an !== exp_an(m_shown_digit) || seg !== exp_seg(m_shown_bcd, m_shown_digit)) begin
                bad++;
                $display("FAIL max_scan cyc=%0d: an=%b seg=%b required an=%b seg=%b", i, an, seg,
                         exp_an(m_shown_digit), exp_seg(m_shown_bcd, m_shown_digit));
            end
            total++;
            if ((an === 3'b011 && seg !== 7'b0100100) || (an !== 3'b011 && seg !== 7'b0010010)) begin
                bad++;
                $display("FAIL max_digits cyc=%0d: an=%b seg=%b required 0100100 on hundreds else 0010010",
                         i, an, seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_load();
        int dones;
        dones = 0;
        res = 8'd100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin res = 8'd7; load = 1'b1; end
            if (i == 4) load = 1'b0;
            total++;
            if (busy !== (m_cnt >= 2) || done !== (m_cnt == 1) || bcd !== m_bcd) begin
                bad++;
                $display("FAIL ignore_ctrl cyc=%0d: busy=%b done=%b bcd=%h required busy=%b done=%b bcd=%h",
                         i, busy, done, bcd, m_cnt >= 2, m_cnt == 1, m_bcd);
            end
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        total++;
        if (bcd !== 12'h100 || dones != 1) begin
            bad++;
            $display("FAIL ignore_value: bcd=%h dones=%0d required bcd=100 dones=1", bcd, dones);
        end
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            total++;
            if (an === 3'b101 && seg !== 7'b1000000) begin
                bad++;
                $display("FAIL ignore_tens_zero: seg=%b required 1000000", seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        res = 8'd200; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            bad++;
            $display("FAIL abort_state: busy=%b done=%b bcd=%h required 0 0 000", busy, done, bcd);
        end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_no_done: dones=%0d required 0", dones);
        end
        res = 8'd45; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        total++;
        if (bcd !== 12'h045) begin
            bad++;
            $display("FAIL abort_reload: bcd=%h required 045", bcd);
        end
        for (int i = 0; i < 3 * SCAN_DIV + 1; i++) begin
            total++;
            if (an !== exp_an(m_shown_digit) || seg !== exp_seg(m_shown_bcd, m_shown_digit)
                || (an === 3'b011 && seg !== 7'b1111111)) begin
                bad++;
                $display("FAIL abort_scan cyc=%0d: an=%b seg=%b required an=%b seg=%b", i, an, seg,
                         exp_an(m_shown_digit), exp_seg(m_shown_bcd, m_shown_digit));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_held_load();
        int dones;
        dones = 0;
        res = 8'd9; load = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 31; i++) begin
            total++;
            if (busy !== (m_cnt >= 2) || done !== (m_cnt == 1) || bcd !== m_bcd) begin
                bad++;
                $display("FAIL held_ctrl cyc=%0d: busy=%b done=%b bcd=%h required busy=%b done=%b bcd=%h",
                         i, busy, done, bcd, m_cnt >= 2, m_cnt == 1, m_bcd);
            end
            if (i > 10 && an !== 3'b110 && seg !== 7'b1111111) begin
                total++;
                bad++;
                $display("FAIL held_blank cyc=%0d: an=%b seg=%b required 1111111", i, an, seg);
            end
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        load = 1'b0;
        total++;
        if (dones != 3 || bcd !== 12'h009) begin
            bad++;
            $display("FAIL held_rate: dones=%0d bcd=%h required dones=3 bcd=009", dones, bcd);
        end
    endtask

    task automatic test_random();
        int v, gap, wait_n;
        for (int n = 0; n < 16; n++) begin
            wait_n = 0;
            while (m_cnt != 0 && wait_n < 20) begin
                @(negedge clk);
                wait_n++;
            end
            total++;
            if (m_cnt != 0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL random_idle_timeout n=%0d: busy=%b required 0", n, busy);
            end
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            v = $urandom_range(0, 255);
            res = 8'(v); load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 3) == 0) res = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 5) == 0) load = 1'b1; else load = 1'b0;
                total++;
                if (busy !== (m_cnt >= 2) || done !== (m_cnt == 1) || bcd !== m_bcd
                    || an !== exp_an(m_shown_digit) || seg !== exp_seg(m_shown_bcd, m_shown_digit)) begin
                    bad++;
                    $display("FAIL random_cycle n=%0d cyc=%0d: busy=%b done=%b bcd=%h an=%b seg=%b required %b %b %h %b %b",
                             n, i, busy, done, bcd, an, seg, m_cnt >= 2, m_cnt == 1, m_bcd,
                             exp_an(m_shown_digit), exp_seg(m_shown_bcd, m_shown_digit));
                end
                @(negedge clk);
            end
            load = 1'b0;
            total++;
            if (bcd !== to_bcd(v)) begin
                bad++;
                $display("FAIL random_value n=%0d res=%0d: bcd=%h required %h", n, v, bcd, to_bcd(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_max();
        test_ignore_load();
        test_abort();
        test_held_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/res_bcd_display.md
Name: res_bcd_display

Overview:
- Downstream consumer of the 8-bit arithmetic result `res` from the lab datapath.
- On a load strobe, it converts the unsigned binary value to 3-digit BCD using a sequential double-dabble, one shift per clock.
- It then drives a 3-digit multiplexed common-anode 7-segment display from the committed BCD value.
- This is the board-facing output stage of the experiment.

Parameters:
- SCAN_DIV, default 4: clock cycles each digit stays enabled before the scan advances; legal range ≥1.
- SEG_ACTIVE_LOW, default 1: 1 means `seg` and `an` are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- res  in  8  unsigned binary value from the upstream datapath.
- load  in  1  request to convert `res`; honoured only in IDLE.
- busy  out  1  high while the conversion is in progress (state SHIFT).
- done  out  1  one-cycle pulse; `bcd` is valid and newly committed.
- bcd  out  12  committed result {hundreds, tens, units}, one nibble each.
- an  out  3  one-hot digit enable; an[0] = units, an[1] = tens, an[2] = hundreds.
- seg  out  7  segment drive, {g,f,e,d,c,b,a}.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state (edge with rst=1): state=IDLE, busy=0, done=0, bcd=12'h000, scan digit=0, scan divider=0.
  - After reset, `an` selects units; `seg` shows "0".
  - rst overrides everything, including an in-flight conversion: it aborts, no done pulse is produced, and bcd is forced to 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on load=1 at edge k, capture `res` into an 8-bit shift register, clear the 12-bit scratch BCD, set the iteration counter to 0, go to SHIFT.
  - SHIFT: on each edge, first add 3 to every scratch nibble ≥5, then shift {scratch, shreg} left by 1 and increment the iteration counter.
  - SHIFT exit: after the 8th shift (edge k+8), commit scratch to `bcd` and go to DONE.
  - DONE: lasts exactly one cycle, then IDLE at edge k+9.
- Outputs by state: busy = (state==SHIFT); done = (state==DONE), driven from the state register, no combinational path from inputs.
- Latency: load sampled at edge k gives done high in the cycle after edge k+8. `bcd` changes only at that edge.
- load rules:
  - load in SHIFT or DONE is ignored; `res` changes during SHIFT have no effect.
  - Back-to-back: load in the IDLE cycle right after DONE is accepted.
  - load held high continuously re-triggers a conversion every 10 cycles.
- Arithmetic: the maximum input is 255, which gives 12'h255. The hundreds nibble never exceeds 2; no overflow is possible.
- Scan:
  - Free-running divider counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→0.
  - The display always shows the committed `bcd`, never the scratch value.
- Leading-zero blanking:
  - Hundreds digit is blank if its nibble is 0.
  - Tens digit is blank if the hundreds and tens nibbles are both 0.
  - Units digit is never blank.
  - Blank means all segments off.
- Segment decode and polarity:
  - Standard decode for digits 0–9; any nibble value >9 decodes to blank (defensive only).
  - With SEG_ACTIVE_LOW=1, both `seg` and `an` are inverted.
- Output timing: `seg` and `an` are registered, so they update one cycle after the digit index changes.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, SHIFT, DONE);
  - segment pattern constants for 0–9 and BLANK, in active-high {g..a} form;
  - the iteration count constant (8).
- One natural sub-module: `seg7_decode`, combinational, taking nibble + blank → 7-bit active-high pattern. The top level applies polarity.

Test Plan:
All checks use SCAN_DIV=4, SEG_ACTIVE_LOW=1.
1. Reset then idle 12 cycles -> bcd=12'h000, busy=0, done=0.
   - an sequence 3'b110 (4 cycles), 3'b101, 3'b011.
   - seg=7'b1000000 for units; 7'b1111111 for tens and hundreds.
2. res=8'd2, load pulse at edge k -> busy high for edges k+1..k+8.
   - done high for exactly one cycle after edge k+8; bcd=12'h002; no other done pulses.
3. res=8'd255 load -> bcd=12'h255.
   - Scan shows hundreds seg=7'b0100100 ("2"), tens and units seg=7'b0010010 ("5").
4. res=8'd100 load; during SHIFT, change res to 8'd7 and pulse load -> bcd=12'h100.
   - Tens shows "0" (7'b1000000), not blank; a single done pulse.
5. Load res=8'd200; assert rst on the 4th SHIFT cycle -> next cycle state=IDLE, busy=0, bcd=12'h000, no done.
   - A subsequent load of 8'd45 yields bcd=12'h045 with hundreds blank.
6. Hold load=1 continuously with res=8'd9 -> done pulses every 10 cycles; bcd=12'h009.
   - Tens and hundreds blank throughout.
